// File: rtl/wb_uart_rx.sv
// wb_uart_rx: Wishbone-attached 8N1 UART receiver with a receive FIFO.
//
// Bit period is DIVIDER+2 clocks. The divider is latched at start-bit
// detection, so rewriting it mid-frame only affects the next frame.
//
// Register map (wb_addr_i[3:2]):
//   0 DIVIDER  RW  32-bit bit-period divider (reset 1)
//   1 DATA     RO  {zeros, head byte}; a read pops the FIFO (empty reads 0)
//   2 STATUS   RW1C [0] NOT_EMPTY [1] FULL [2] OVERRUN [3] FRAME_ERR
//                   [15:8] fill count
//   3 SANITY   RO  32'hA17EB0B0
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   uart_rx_i             serial input, idle high
//   wb_addr_i/wb_data_i/wb_sel_i/wb_we_i/wb_cyc_i/wb_stb_i  Wishbone slave inputs
//                         (wb_sel_i is ignored)
//   wb_ack_o, wb_data_o   single-cycle acknowledge; data is 0 while ack is low
//   rx_irq_o              interrupt
//
// Optional feature: define WB_UART_RX_IRQ_EN to drive rx_irq_o with a
// registered NOT_EMPTY | OVERRUN | FRAME_ERR; otherwise it is tied low.

module wb_uart_rx #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     uart_rx_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     rx_irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Line synchroniser; rx_prev_q gives the previous synchronised bit for
    // falling-edge detection.
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [32:0] cnt_q, cnt_d;
    logic [31:0] div_work_q, div_work_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [32:0] period, half;
    logic        push, frame_set;
    logic [31:0] divider_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_work_d = div_work_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frame_set  = 1'b0;
        // 33-bit arithmetic so DIVIDER = 32'hFFFF_FFFF does not wrap.
        period     = {1'b0, div_work_q} + 33'd2;
        half       = period >> 1;
        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d    = S_START;
                    div_work_d = divider_q;
                    cnt_d      = 33'd1;
                end
            end
            S_START: begin
                if (cnt_q >= half) begin
                    cnt_d   = 33'd1;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 33'd1;
                end
            end
            S_DATA: begin
                if (cnt_q >= period) begin
                    cnt_d   = 33'd1;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 33'd1;
                end
            end
            S_STOP: begin
                if (cnt_q >= period) begin
                    cnt_d   = 33'd0;
                    state_d = S_IDLE;
                    if (rx_sync_q) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 33'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_work_q <= 32'd1;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_work_q <= div_work_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_pend_q, pop_pend_d;
    logic             full, empty, pop, push_ok, overrun_set;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // The pop is decided at request time and executed in the ack cycle.
    assign pop   = pop_pend_q;
    // A simultaneous pop frees a slot, so a full FIFO still takes the byte.
    assign push_ok     = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Wishbone slave
    // ------------------------------------------------------------------
    logic                     ack_q, ack_d;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]              divider_d;
    logic                     overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                     req;
    logic [1:0]               sel;
    logic [31:0]              wdata32, rd32, status32;
    logic                     unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_addr_i};
    assign req       = wb_cyc_i && wb_stb_i && !ack_q;
    assign sel       = wb_addr_i[3:2];
    assign wdata32   = 32'(wb_data_i);
    assign status32  = {16'd0, 8'(count_q), 4'd0, frame_err_q, overrun_q, full, !empty};

    always_comb begin
        unique case (sel)
            2'd0:    rd32 = divider_q;
            2'd1:    rd32 = empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q]};
            2'd2:    rd32 = status32;
            default: rd32 = 32'hA17E_B0B0;
        endcase
    end

    always_comb begin
        ack_d       = req;
        rdata_d     = (req && !wb_we_i) ? WB_DATA_WIDTH'(rd32) : '0;
        pop_pend_d  = req && !wb_we_i && (sel == 2'd1) && !empty;
        divider_d   = divider_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (req && wb_we_i && (sel == 2'd0)) begin
            divider_d = wdata32;
        end
        if (req && wb_we_i && (sel == 2'd2)) begin
            if (wdata32[2]) overrun_d   = 1'b0;
            if (wdata32[3]) frame_err_d = 1'b0;
        end
        // Set after clear so a same-cycle event is never lost.
        if (overrun_set) overrun_d   = 1'b1;
        if (frame_set)   frame_err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_pend_q  <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            divider_q   <= 32'd1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_pend_q  <= pop_pend_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            divider_q   <= divider_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_data_o = rdata_q;

`ifdef WB_UART_RX_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = !empty || overrun_q || frame_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign rx_irq_o = irq_q;
`else
    assign rx_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed testbench for wb_uart_rx with a byte scoreboard and status model.

module tb_wb_uart_rx;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_DIV = 32'h0, A_DATA = 32'h4, A_STAT = 32'h8, A_SAN = 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        line = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic       exp_ovr = 1'b0;
    logic       exp_fe  = 1'b0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    wb_uart_rx dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .uart_rx_i (line),
        .wb_addr_i (addr),
        .wb_data_i (wdat),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_ack_o  (ack),
        .wb_data_o (rdat),
        .rx_irq_o  (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = sb.size();
        return {16'd0, 8'(n), 4'd0, exp_fe, exp_ovr, (n == DEPTH), (n != 0)};
    endfunction

    // All drivers change inputs 1 time unit after a rising edge.
    task automatic drive(input logic v, input int n);
        line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int p);
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) drive(b[i], p);
        drive(stop_ok, p);
        drive(1'b1, 2);
        if (stop_ok) begin
            if (sb.size() < DEPTH) sb.push_back(b);
            else exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
    endtask

    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic hold, output logic [31:0] q);
        int lat = 0;
        logic got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack) got = 1'b1;
        end
        q = rdat;
        check("ack_latency", lat, got ? 1 : 0);
        if (hold) begin
            @(posedge clk); #1;
            check("ack_one_cycle", {31'd0, ack}, 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("idle_data", rdat, 32'd0);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
        wb_cycle(a, 1'b0, 32'd0, 1'b0, q);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_cycle(a, 1'b1, d, 1'b0, dummy);
    endtask

    task automatic read_data(input string tag);
        logic [7:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        wb_read(A_DATA, rd);
        check(tag, rd, {24'd0, e});
    endtask

    task automatic read_status(input string tag);
        wb_read(A_STAT, rd);
        check(tag, rd, exp_status());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_data", rdat, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(A_DIV, rd);
        check("rst_divider", rd, 32'd1);
        read_status("rst_status");

        // Single byte at P=5
        wb_write(A_DIV, 32'd3);
        send_byte(8'h55, 1'b1, 5);
`ifdef WB_UART_RX_IRQ_EN
        check("irq_rise", {31'd0, irq}, 32'd1);
`else
        check("irq_tied", {31'd0, irq}, 32'd0);
`endif
        read_status("status_one");
        read_data("data_55");
        repeat (2) @(posedge clk);
        #1;
        check("irq_fall", {31'd0, irq}, 32'd0);
        read_status("status_after_pop");

        // Overflow: DEPTH+1 bytes without reads, P=12
        wb_write(A_DIV, 32'd10);
        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1, 12);
        read_status("status_full_ovr");
        for (int i = 0; i < DEPTH; i++) read_data("data_fifo_order");
        read_status("status_ovr_empty");
        wb_write(A_STAT, 32'h4);
        exp_ovr = 1'b0;
        read_status("status_ovr_clr");

        // Framing error, then a glitch on the idle line
        send_byte(8'hA5, 1'b0, 12);
        read_status("status_frame_err");
        wb_write(A_STAT, 32'h8);
        exp_fe = 1'b0;
        read_status("status_fe_clr");
        drive(1'b0, 1);
        drive(1'b1, 40);
        read_status("status_glitch");
        send_byte(8'h81, 1'b1, 12);
        read_data("data_81");

        // Reset during data bit 4
        drive(1'b0, 12);
        for (int i = 0; i < 4; i++) drive(1'b0, 12);
        drive(1'b1, 6);
        rst_n = 1'b0;
        sb.delete();
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        drive(1'b1, 3);
        rst_n = 1'b1;
        drive(1'b1, 4);
        wb_read(A_DIV, rd);
        check("divider_after_rst", rd, 32'd1);
        send_byte(8'h3C, 1'b1, 3);
        read_status("status_3c");
        read_data("data_3c");
        read_status("status_3c_empty");

        // Empty DATA read and SANITY
        wb_cycle(A_DATA, 1'b0, 32'd0, 1'b1, rd);
        check("empty_data", rd, 32'd0);
        wb_read(A_SAN, rd);
        check("sanity", rd, 32'hA17E_B0B0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_uart_rx.md
WB_UART_RX -- requirements
Module: wb_uart_rx

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-003 SHALL have parameter WB_SEL_WIDTH, default WB_DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..256).
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports: clk_i input 1 system clock; rst_ni input 1 async active-low reset.
REQ-006 Remaining ports: uart_rx_i input 1 serial line (idle high); wb_addr_i input WB_ADDR_WIDTH; wb_data_i input WB_DATA_WIDTH; wb_sel_i input WB_SEL_WIDTH (ignored); wb_we_i input 1; wb_cyc_i input 1; wb_stb_i input 1; wb_ack_o output 1; wb_data_o output WB_DATA_WIDTH; rx_irq_o output 1 interrupt.

Function
REQ-007 uart_rx_i SHALL pass a 2-flop synchroniser (reset value 1); all line logic uses the synchronised bit.
REQ-008 Register select = wb_addr_i[3:2]: 0 DIVIDER (RW, 32 bit), 1 DATA (RO, pop), 2 STATUS (RW1C), 3 SANITY (RO, 32'hA17EB0B0).
REQ-009 Bit period P SHALL be DIVIDER+2 clocks (matches transmitter); DIVIDER is copied to a working register at start-bit detection, so writes mid-frame affect only the next frame.
REQ-010 FSM states IDLE, START, DATA, STOP; IDLE->START on synchronised high-to-low transition only (line held low never retriggers).
REQ-011 START: after (DIVIDER+2)>>1 clocks sample line; low -> DATA, high -> IDLE (glitch, nothing recorded).
REQ-012 DATA: sample every P clocks, 8 bits LSB first; after bit 7 -> STOP.
REQ-013 STOP: sample after P clocks; high -> push byte and IDLE; low -> set FRAME_ERR, discard byte, IDLE.
REQ-014 Push when FIFO full SHALL drop the byte and set OVERRUN; FIFO contents unchanged.
REQ-015 Wishbone: wb_ack_o SHALL assert exactly one cycle, the cycle after cyc&stb seen with ack low; no wait states, every address acknowledged.
REQ-016 DATA read: wb_data_o = {zeros, head byte}, pop in the ack cycle; empty -> returns 0, no pop.
REQ-017 STATUS read bits: [0] NOT_EMPTY, [1] FULL, [2] OVERRUN, [3] FRAME_ERR, [15:8] fill count, rest 0; write 1 to bit 2/3 clears it, other bits unaffected.
REQ-018 Push and pop in the same cycle SHALL both occur; count unchanged; full FIFO with simultaneous pop accepts the push without overrun.
REQ-019 Sticky flag set and W1C clear in same cycle: set wins.
REQ-020 wb_data_o SHALL be 0 whenever wb_ack_o is low.

Reset
REQ-021 rst_ni low SHALL immediately: FSM IDLE, FIFO empty, pointers 0, DIVIDER=1, OVERRUN=FRAME_ERR=0, wb_ack_o=0, wb_data_o=0, rx_irq_o=0, synchroniser=1.
REQ-022 Reset mid-frame SHALL abandon the frame; no partial byte ever appears in the FIFO.

Configuration
REQ-023 Macro WB_UART_RX_IRQ_EN defined: rx_irq_o = NOT_EMPTY | OVERRUN | FRAME_ERR, registered; undefined: rx_irq_o tied 0, no interrupt logic.

Verification
REQ-024 DIVIDER=3 (P=5), send 0x55 8N1 -> STATUS[0]=1, count=1; DATA read returns 0x00000055; next STATUS[0]=0.
REQ-025 DIVIDER=10, send FIFO_DEPTH+1 bytes 0x00..0x08 without reads -> first 8 read back in order, OVERRUN=1; write STATUS 0x4 -> OVERRUN=0.
REQ-026 Stop bit driven low on byte 0xA5 -> FRAME_ERR=1, FIFO count 0; 1-clock low glitch on idle line -> no state change.
REQ-027 Assert rst_ni low during data bit 4, release, send 0x3C -> only 0x3C in FIFO, DIVIDER reads back 1.
REQ-028 Read empty DATA -> ack one cycle, data 0; read SANITY -> 0xA17EB0B0; with WB_UART_RX_IRQ_EN, rx_irq_o rises after first byte stored and falls after pop.
